// File: rtl/avalon_arb_pkg.sv
// Shared types for the Avalon burst arbiter.
// Grant states and the default read-beat limit.
package avalon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT_RD,
        GNT_WR
    } gnt_state_e;

    localparam int MAX_PENDING_DEF = 16;

endpackage

// File: rtl/avalon_arb_pending_counter.sv
// Outstanding read-beat counter for the Avalon burst arbiter.
// Adds a burst on each accepted read, drops one per returned beat.
module avalon_arb_pending_counter #(
    parameter int BURST_WIDTH       = 4,
    parameter int MAX_PENDING_BEATS = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 inc_i,
    input  logic [BURST_WIDTH-1:0]               burst_i,
    input  logic                                 dec_i,
    output logic [$clog2(MAX_PENDING_BEATS):0]   count_o
);

    localparam int CW = $clog2(MAX_PENDING_BEATS) + 1;

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] add_beats, sub_beats;

    always_comb begin
        add_beats = '0;
        sub_beats = '0;
        if (inc_i) begin
            add_beats = (burst_i == '0) ? CW'(1) : CW'(burst_i);
        end
        // A stray returned beat never wraps the count below zero
        if (dec_i && (count_q != '0)) begin
            sub_beats = CW'(1);
        end
        count_d = count_q + add_beats - sub_beats;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/avalon_burst_arbiter.sv
// Two-client Avalon-MM burst arbiter: one read client, one write client,
// round-robin grant onto a shared master with a read-beat credit limit.
module avalon_burst_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int BYTE_ENABLE_WIDTH = 4,
    parameter int BURST_WIDTH       = 4,
    parameter int MAX_PENDING_BEATS = MAX_PENDING_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDRESS_WIDTH-1:0]     rd_address,
    input  logic                         rd_read,
    input  logic [BURST_WIDTH-1:0]       rd_burstcount,
    output logic                         rd_waitrequest,
    output logic                         rd_readdatavalid,
    output logic [DATA_WIDTH-1:0]        rd_readdata,
    input  logic [ADDRESS_WIDTH-1:0]     wr_address,
    input  logic                         wr_write,
    input  logic [DATA_WIDTH-1:0]        wr_writedata,
    input  logic [BYTE_ENABLE_WIDTH-1:0] wr_byteenable,
    input  logic [BURST_WIDTH-1:0]       wr_burstcount,
    output logic                         wr_waitrequest,
    output logic [ADDRESS_WIDTH-1:0]     m_address,
    output logic                         m_read,
    output logic                         m_write,
    output logic [BURST_WIDTH-1:0]       m_burstcount,
    output logic [DATA_WIDTH-1:0]        m_writedata,
    output logic [BYTE_ENABLE_WIDTH-1:0] m_byteenable,
    input  logic                         m_waitrequest,
    input  logic                         m_readdatavalid,
    input  logic [DATA_WIDTH-1:0]        m_readdata
);

    localparam int CW = $clog2(MAX_PENDING_BEATS) + 1;

    gnt_state_e             state_q, state_d;
    logic                   last_rd_q, last_rd_d;
    logic                   started_q, started_d;
    logic [BURST_WIDTH-1:0] beat_q, beat_d;
    logic [BURST_WIDTH-1:0] rem;
    logic [BURST_WIDTH-1:0] rd_bc_eff, wr_bc_eff;
    logic [CW-1:0]          pend_cnt;
    logic [31:0]            rd_need;
    logic                   rd_fits, rd_acc, wr_acc;

    assign rd_bc_eff = (rd_burstcount == '0) ? BURST_WIDTH'(1) : rd_burstcount;
    assign wr_bc_eff = (wr_burstcount == '0) ? BURST_WIDTH'(1) : wr_burstcount;
    assign rd_need   = 32'(pend_cnt) + 32'(rd_bc_eff);
    assign rd_fits   = rd_read && (rd_need <= 32'(MAX_PENDING_BEATS));
    assign rd_acc    = (state_q == GNT_RD) && rd_read && !m_waitrequest;
    assign wr_acc    = (state_q == GNT_WR) && wr_write && !m_waitrequest;

    assign rd_readdatavalid = m_readdatavalid;
    assign rd_readdata      = m_readdata;

    avalon_arb_pending_counter #(
        .BURST_WIDTH      (BURST_WIDTH),
        .MAX_PENDING_BEATS(MAX_PENDING_BEATS)
    ) u_pend (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (rd_acc),
        .burst_i(rd_burstcount),
        .dec_i  (m_readdatavalid),
        .count_o(pend_cnt)
    );

    always_comb begin
        state_d        = state_q;
        last_rd_d      = last_rd_q;
        started_d      = started_q;
        beat_d         = beat_q;
        rem            = started_q ? beat_q : wr_bc_eff;
        m_address      = '0;
        m_read         = 1'b0;
        m_write        = 1'b0;
        m_burstcount   = '0;
        m_writedata    = '0;
        m_byteenable   = '0;
        rd_waitrequest = 1'b1;
        wr_waitrequest = 1'b1;
        unique case (state_q)
            IDLE: begin
                // A read that would overrun the credit limit yields to write
                if (rd_fits && (!wr_write || !last_rd_q)) begin
                    state_d   = GNT_RD;
                    last_rd_d = 1'b1;
                end else if (wr_write) begin
                    state_d   = GNT_WR;
                    last_rd_d = 1'b0;
                    started_d = 1'b0;
                    beat_d    = '0;
                end
            end
            GNT_RD: begin
                m_address      = rd_address;
                m_read         = rd_read;
                m_burstcount   = rd_burstcount;
                rd_waitrequest = m_waitrequest;
                if (rd_acc) begin
                    state_d = IDLE;
                end
            end
            GNT_WR: begin
                m_address      = wr_address;
                m_write        = wr_write;
                m_burstcount   = wr_burstcount;
                m_writedata    = wr_writedata;
                m_byteenable   = wr_byteenable;
                wr_waitrequest = m_waitrequest;
                if (wr_acc) begin
                    beat_d    = rem - BURST_WIDTH'(1);
                    started_d = 1'b1;
                    if (beat_d == '0) begin
                        state_d   = IDLE;
                        started_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_rd_q <= 1'b0;
            started_q <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            started_q <= started_d;
            beat_q    <= beat_d;
        end
    end

endmodule
